// File: rtl/fifo_merge_sched_pkg.sv
// Shared types for the FIFO merge scheduler: FSM states, occupancy count type,
// default output-buffer entry record and the channel-tag width helper.
package fifo_merge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        READ,
        DRAIN
    } state_t;

    typedef logic [15:0] count_t;

    localparam int unsigned NCH_DEF    = 4;
    localparam int unsigned DWIDTH_DEF = 16;
    localparam int unsigned CHW_DEF    = $clog2(NCH_DEF);

    typedef struct packed {
        logic [DWIDTH_DEF-1:0] data;
        logic [CHW_DEF-1:0]    chan;
        logic                  sob;
        logic                  eob;
    } obuf_entry_t;

    function automatic int unsigned chan_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_merge_sched_obuf.sv
// Two-entry valid/ready output buffer (FIFO order); occ_o feeds the read credit check.
import fifo_merge_pkg::*;

module merge_obuf #(
    parameter type entry_t = obuf_entry_t
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  entry_t     entry_i,
    input  logic       ready_i,
    output logic       valid_o,
    output entry_t     entry_o,
    output logic [1:0] occ_o
);

    entry_t     e0_q, e0_d, e1_q, e1_d;
    logic [1:0] occ_q, occ_d;
    logic       pop;

    assign valid_o = (occ_q != 2'd0);
    assign entry_o = e0_q;
    assign occ_o   = occ_q;
    assign pop     = valid_o & ready_i;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        if (pop) begin
            e0_d  = e1_q;
            occ_d = occ_q - 2'd1;
        end
        // Push lands in the slot left free after this cycle's pop.
        if (push_i) begin
            if (occ_d == 2'd0) begin
                e0_d = entry_i;
            end else begin
                e1_d = entry_i;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_merge_sched.sv
// Round-robin burst scheduler merging NCH channel FIFOs into one tagged stream.
// Optional partial bursts after an idle timeout: define FIFO_MERGE_PARTIAL_EN.
module fifo_merge_sched
    import fifo_merge_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned BURST   = 8,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned CHW    = chan_width(NCH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [16*NCH-1:0]     rcount_i,
    input  logic [DWIDTH*NCH-1:0] data_i,
    input  logic [NCH-1:0]        valid_i,
    output logic [NCH-1:0]        ren_o,
    output logic [DWIDTH-1:0]     data_o,
    output logic [CHW-1:0]        chan_o,
    output logic                  sob_o,
    output logic                  eob_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic [CHW-1:0]        grant_o
);

    if (NCH < 2 || NCH > 16 || BURST < 1 || BURST > 65535 || TIMEOUT < 1) begin : g_param_check
        $error("fifo_merge_sched: parameter out of range");
    end

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic [CHW-1:0]    chan;
        logic              sob;
        logic              eob;
    } entry_t;

    localparam count_t BURST_C = count_t'(BURST);

    state_t         state_q, state_d;
    logic [CHW-1:0] grant_q, grant_d;
    logic [CHW-1:0] rr_q, rr_d;
    count_t         rem_q, rem_d;
    logic           first_q, first_d;
    logic           infl_q, infl_d;
    logic           infl_sob_q, infl_sob_d;
    logic           infl_eob_q, infl_eob_d;

    count_t            rc [NCH];
    logic              found;
    logic [CHW-1:0]    pick;
    logic              valid_sel;
    logic [DWIDTH-1:0] data_sel;
    logic              push, pop, credit;
    logic [1:0]        occ;
    logic [2:0]        pend;
    entry_t            entry_in, entry_out;

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            rc[c] = rcount_i[16*c +: 16];
        end
    end

    // Round-robin search for a channel holding a full burst, starting at rr_q.
    always_comb begin
        int unsigned    idx;
        logic [CHW-1:0] idx_c;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        idx_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NCH) idx = idx - NCH;
            idx_c = CHW'(idx);
            if (!found && rc[idx_c] >= BURST_C) begin
                found = 1'b1;
                pick  = idx_c;
            end
        end
    end

`ifdef FIFO_MERGE_PARTIAL_EN
    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

    logic [31:0]    idle_q, idle_d;
    logic           p_found;
    logic [CHW-1:0] p_pick;
    count_t         p_cnt;

    always_comb begin
        int unsigned    pidx;
        logic [CHW-1:0] pidx_c;
        p_found = 1'b0;
        p_pick  = '0;
        p_cnt   = '0;
        pidx    = 0;
        pidx_c  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            pidx = 32'(rr_q) + i;
            if (pidx >= NCH) pidx = pidx - NCH;
            pidx_c = CHW'(pidx);
            if (!p_found && rc[pidx_c] != '0) begin
                p_found = 1'b1;
                p_pick  = pidx_c;
                p_cnt   = (rc[pidx_c] > BURST_C) ? BURST_C : rc[pidx_c];
            end
        end
    end
`endif

    always_comb begin
        data_sel = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (grant_q == CHW'(c)) data_sel = data_i[c*DWIDTH +: DWIDTH];
        end
    end

    assign valid_sel = valid_i[grant_q];
    assign push      = infl_q & valid_sel;
    assign pop       = valid_o & ready_i;
    // Credit counts the word leaving this cycle, so a burst streams at 1 word/cycle.
    assign pend      = 3'(occ) + 3'(infl_q) - 3'(pop);
    assign credit    = (pend < 3'd2);

    always_comb begin
        logic take;
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        rem_d      = rem_q;
        first_d    = first_q;
        infl_d     = 1'b0;
        infl_sob_d = infl_sob_q;
        infl_eob_d = infl_eob_q;
        ren_o      = '0;
        take       = 1'b0;
`ifdef FIFO_MERGE_PARTIAL_EN
        idle_d     = idle_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef FIFO_MERGE_PARTIAL_EN
                idle_d = '0;
`endif
                if (en_i) state_d = ARB;
            end
            ARB: begin
                if (found) begin
                    grant_d = pick;
                    rem_d   = BURST_C;
                    take    = 1'b1;
                end
`ifdef FIFO_MERGE_PARTIAL_EN
                else if (idle_q >= TIMEOUT_C && p_found) begin
                    grant_d = p_pick;
                    rem_d   = p_cnt;
                    take    = 1'b1;
                end
                idle_d = take ? '0 : ((idle_q < TIMEOUT_C) ? idle_q + 32'd1 : idle_q);
`endif
                if (take) begin
                    rr_d    = (grant_d == CHW'(NCH - 1)) ? '0 : grant_d + 1'b1;
                    first_d = 1'b1;
                    state_d = READ;
                end else if (!en_i) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (credit) begin
                    ren_o      = NCH'(1) << grant_q;
                    infl_d     = 1'b1;
                    infl_sob_d = first_q;
                    infl_eob_d = (rem_q == 16'd1);
                    first_d    = 1'b0;
                    rem_d      = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!infl_q || valid_sel) state_d = en_i ? ARB : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_q       <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            infl_q     <= 1'b0;
            infl_sob_q <= 1'b0;
            infl_eob_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            infl_q     <= infl_d;
            infl_sob_q <= infl_sob_d;
            infl_eob_q <= infl_eob_d;
        end
    end

`ifdef FIFO_MERGE_PARTIAL_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`endif

    assign entry_in = '{data: data_sel, chan: grant_q, sob: infl_sob_q, eob: infl_eob_q};

    merge_obuf #(
        .entry_t (entry_t)
    ) u_obuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .entry_i (entry_in),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .entry_o (entry_out),
        .occ_o   (occ)
    );

    assign data_o  = entry_out.data;
    assign chan_o  = entry_out.chan;
    assign sob_o   = entry_out.sob;
    assign eob_o   = entry_out.eob;
    assign busy_o  = (state_q != IDLE);
    assign grant_o = grant_q;

endmodule

// File: tb/tb_fifo_merge_sched.sv
// Scoreboard bench for fifo_merge_sched: FIFO read-port model, burst-level reference, monitor.
module tb_fifo_merge_sched;

    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int BURST = 8;

    logic              clk, rst_i, en_i, ready_i;
    logic [16*NCH-1:0] rcount_i;
    logic [DW*NCH-1:0] data_i;
    logic [NCH-1:0]    valid_i, ren_o;
    logic [DW-1:0]     data_o;
    logic [1:0]        chan_o, grant_o;
    logic              sob_o, eob_o, valid_o, busy_o;

    fifo_merge_sched #(
        .NCH     (NCH),
        .DWIDTH  (DW),
        .BURST   (BURST),
        .TIMEOUT (16)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .rcount_i (rcount_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .ren_o    (ren_o),
        .data_o   (data_o),
        .chan_o   (chan_o),
        .sob_o    (sob_o),
        .eob_o    (eob_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .busy_o   (busy_o),
        .grant_o  (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  chan;
        logic        sob;
        logic        eob;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          load_req[NCH];
    int          cons[NCH];
    int          mrr;
    int          rd_cnt[NCH];
    int          ready_mode = 0;
    logic [NCH-1:0] ren_s = '0;
    logic        rst_s = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input int c, input int n);
        return 16'((c << 12) + (n % 4096));
    endfunction

    // FIFO read ports: 1-cycle read latency, occupancy is queue depth.
    initial begin
        logic [15:0] fq[NCH][$];
        int          wr_cnt[NCH];
        valid_i  = '0;
        data_i   = '0;
        rcount_i = '0;
        for (int c = 0; c < NCH; c++) wr_cnt[c] = 0;
        forever begin
            @(posedge clk);
            #1;
            valid_i = '0;
            for (int c = 0; c < NCH; c++) begin
                if (ren_s[c] && fq[c].size() > 0) begin
                    data_i[c*DW +: DW] = fq[c].pop_front();
                    valid_i[c] = 1'b1;
                end
                while (wr_cnt[c] < load_req[c]) begin
                    fq[c].push_back(word_of(c, wr_cnt[c]));
                    wr_cnt[c]++;
                end
                if (rst_s) begin
                    fq[c].delete();
                    wr_cnt[c] = load_req[c];
                end
                rcount_i[c*16 +: 16] = 16'(fq[c].size());
            end
        end
    end

    initial begin
        int rk = 0;
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       ready_i = (rk % 3 == 0);
                2:       ready_i = ($urandom_range(0, 99) < 70);
                default: ready_i = 1'b1;
            endcase
            rk++;
        end
    end

    // Monitor: scoreboard pops, credit bound, one-hot read enable, stall stability.
    initial begin
        int          outst = 0;
        logic        stall_prev = 1'b0;
        logic [20:0] prev_vec = '0;
        int          acc;
        exp_t        e;
        for (int c = 0; c < NCH; c++) rd_cnt[c] = 0;
        forever begin
            @(negedge clk);
            ren_s = ren_o;
            rst_s = rst_i;
            if (rst_i) begin
                outst = 0;
                stall_prev = 1'b0;
                for (int c = 0; c < NCH; c++) rd_cnt[c] = 0;
            end else begin
                acc = (valid_o && ready_i) ? 1 : 0;
                check("ren_onehot0", 32'($onehot0(ren_o)), 1);
                if (ren_o != '0) check("credit_pending_le2", 32'(outst - acc + 1 <= 2), 1);
                for (int c = 0; c < NCH; c++) if (ren_o[c]) rd_cnt[c]++;
                outst = outst + ((ren_o != '0) ? 1 : 0) - acc;
                if (stall_prev)
                    check("stall_hold", 32'({valid_o, sob_o, eob_o, chan_o, data_o}), 32'(prev_vec));
                stall_prev = valid_o && !ready_i;
                prev_vec   = {valid_o, sob_o, eob_o, chan_o, data_o};
                if (acc != 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_word: got chan=%0d data=%h, expected no word at %0t",
                                 chan_o, data_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("word{chan,sob,eob,data}", 32'({chan_o, sob_o, eob_o, data_o}),
                              32'({e.chan, e.sob, e.eob, e.data}));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int c, input int n);
        load_req[c] += n;
    endtask

    // Reference: repeatedly grant the first channel from the RR pointer holding a full burst.
    task automatic plan(input int max_bursts);
        int avail[NCH];
        int g, c, nb;
        exp_t e;
        for (int i = 0; i < NCH; i++) avail[i] = load_req[i] - cons[i];
        nb = 0;
        while (nb < max_bursts) begin
            g = -1;
            for (int i = 0; i < NCH; i++) begin
                c = (mrr + i) % NCH;
                if (g < 0 && avail[c] >= BURST) g = c;
            end
            if (g < 0) break;
            for (int k = 0; k < BURST; k++) begin
                e.data = word_of(g, cons[g] + k);
                e.chan = 2'(g);
                e.sob  = (k == 0);
                e.eob  = (k == BURST - 1);
                exp_q.push_back(e);
            end
            cons[g]  += BURST;
            avail[g] -= BURST;
            mrr = (g + 1) % NCH;
            nb++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int c = 0; c < NCH; c++) cons[c] = load_req[c];
        mrr = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        en_i  = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check("drain_remaining", 32'(exp_q.size()), 0);
    endtask

    task automatic stop_en();
        int n = 0;
        en_i = 1'b0;
        while (busy_o && n < 50) begin
            tick();
            n++;
        end
        check("busy_fall", 32'(busy_o), 0);
    endtask

    initial begin
        int n, lat;
        exp_t e;
        rst_i = 1'b1;
        en_i  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            load_req[c] = 0;
            cons[c] = 0;
        end
        mrr = 0;
        repeat (3) tick();
        check("rst_ren", 32'(ren_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_sob_eob", 32'({sob_o, eob_o}), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_grant", 32'(grant_o), 0);
        check("rst_data_chan", 32'({chan_o, data_o}), 0);
        rst_i = 1'b0;
        model_reset();

        // Single burst on channel 2, latency ARB -> valid_o.
        load(2, 8);
        tick();
        tick();
        plan(1000);
        en_i = 1'b1;
        n = 0;
        while (!busy_o && n < 20) begin tick(); n++; end
        lat = 0;
        while (!valid_o && lat < 20) begin tick(); lat++; end
        check("arb_to_valid_cycles", 32'(lat), 3);
        wait_done(200);
        check("ch2_reads", 32'(rd_cnt[2]), 8);
        check("grant_ch2", 32'(grant_o), 2);
        stop_en();

        // All channels 20 words: RR order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int c = 0; c < NCH; c++) load(c, 20);
        tick();
        tick();
        plan(1000);
        en_i = 1'b1;
        wait_done(1000);
        for (int c = 0; c < NCH; c++) check("rr_reads_per_ch", 32'(rd_cnt[c]), 16);
        stop_en();

        // Channel 1 with ready pattern 1,0,0.
        do_reset();
        load(1, 16);
        ready_mode = 1;
        tick();
        tick();
        plan(1000);
        en_i = 1'b1;
        wait_done(1000);
        check("stall_ch1_reads", 32'(rd_cnt[1]), 16);
        stop_en();

        // Randomized occupancies and random backpressure, several rounds.
        do_reset();
        ready_mode = 2;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NCH; c++) load(c, $urandom_range(0, 24));
            tick();
            tick();
            plan(1000);
            en_i = 1'b1;
            wait_done(3000);
            stop_en();
        end
        ready_mode = 0;

        // en_i dropped during the burst: burst completes, then IDLE.
        do_reset();
        load(0, 16);
        tick();
        tick();
        plan(1);
        en_i = 1'b1;
        n = 0;
        while (rd_cnt[0] < 3 && n < 50) begin tick(); n++; end
        en_i = 1'b0;
        wait_done(200);
        stop_en();
        check("en_drop_reads", 32'(rd_cnt[0]), 8);

        // Reset mid-READ.
        do_reset();
        load(1, 16);
        tick();
        tick();
        plan(1000);
        en_i = 1'b1;
        n = 0;
        while (rd_cnt[1] < 2 && n < 50) begin tick(); n++; end
        rst_i = 1'b1;
        en_i  = 1'b0;
        tick();
        rst_i = 1'b0;
        model_reset();
        check("midrst_ren", 32'(ren_o), 0);
        check("midrst_valid", 32'(valid_o), 0);
        check("midrst_busy", 32'(busy_o), 0);
        repeat (4) tick();
        load(0, 8);
        load(1, 8);
        tick();
        tick();
        plan(1000);
        en_i = 1'b1;
        wait_done(500);
        stop_en();

        // Partial burst: three words on channel 3 only.
        do_reset();
        load(3, 3);
        tick();
        tick();
`ifdef FIFO_MERGE_PARTIAL_EN
        for (int k = 0; k < 3; k++) begin
            e.data = word_of(3, cons[3] + k);
            e.chan = 2'd3;
            e.sob  = (k == 0);
            e.eob  = (k == 2);
            exp_q.push_back(e);
        end
        cons[3] += 3;
        en_i = 1'b1;
        wait_done(200);
        check("partial_reads", 32'(rd_cnt[3]), 3);
`else
        en_i = 1'b1;
        repeat (40) tick();
        check("no_partial_reads", 32'(rd_cnt[3]), 0);
        check("no_partial_busy", 32'(busy_o), 1);
`endif
        stop_en();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
